bsg_fifo_mod: RTL

// Parametrised baseband symbol generator. A register bus loads a DEPTH-byte TX FIFO. Each byte is split into
// SYM_BITS-wide symbols (MSB first), optionally Gray-coded, and driven on OUT as a full-scale amplitude level.

---
 rtl/bsg_fifo_mod.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/bsg_fifo_mod.sv
// Baseband symbol generator: bus-loaded byte FIFO -> SYM_BITS symbols (MSB first, optional Gray) -> full-scale OUT level.
// Latency: pop on edge t drives symbol 0 on OUT from t+1; each symbol is held DIV+1 SYS_CLK cycles.
// Backpressure: none on the bus; a DATA write into a full FIFO is dropped and sets the sticky OVF flag.
//
// Ports:
//   SYS_CLK, rst_n        clock and synchronous active-low reset
//   sel, we, addr         bus strobe (one access per cycle), 0=write/1=read, register address
//   Data_in, Data_out     write data, registered read data (valid the cycle after the read edge)
//   OUT                   modulated symbol level, 0 while idle
//   BSG_INT               transmit-complete interrupt (INTFLAG & INTMSK)
module bsg_fifo_mod #(
  parameter int DEPTH    = 8,
  parameter int SYM_BITS = 2,
  parameter int OUT_W    = 8,
  parameter int DIV_W    = 8
) (
  input  logic             SYS_CLK,
  input  logic             rst_n,
  input  logic             sel,
  input  logic             we,
  input  logic [7:0]       addr,
  input  logic [7:0]       Data_in,
  output logic [7:0]       Data_out,
  output logic [OUT_W-1:0] OUT,
  output logic             BSG_INT
);

  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NSYM = 8 / SYM_BITS;
  localparam int SW   = 4;

  localparam logic [7:0] A_CTRL  = 8'h00;
  localparam logic [7:0] A_DATA  = 8'h01;
  localparam logic [7:0] A_DIV   = 8'h02;
  localparam logic [7:0] A_LEVEL = 8'h03;
  localparam logic [7:0] A_STAT  = 8'h04;

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  // Control / status registers
  logic             txen, intmsk, intflag, gray_en, ovf;
  logic [DIV_W-1:0] div_q;

  // FIFO storage and bookkeeping
  logic [7:0]       mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;

  // Shifter
  state_t           state;
  logic [7:0]       shreg;
  logic [SW-1:0]    sym_idx;
  logic [DIV_W-1:0] div_cnt;

  logic       wr_en, rd_en, wr_ctrl, wr_data, wr_div, wr_stat;
  logic       txen_nxt, empty, full, busy;
  logic       sym_end, last_final, abort, pop, push, set_int;
  logic [7:0] head_byte, shreg_sh, rdata;

  // Gray-code a symbol when enabled.
  function automatic logic [SYM_BITS-1:0] code_sym(input logic [SYM_BITS-1:0] s, input logic g);
    return g ? (s ^ (s >> 1)) : s;
  endfunction

  // Left-align the coded symbol and replicate it down to the LSB so that
  // the minimum symbol maps to 0 and the maximum symbol maps to all ones.
  function automatic logic [OUT_W-1:0] level(input logic [SYM_BITS-1:0] c);
    logic [OUT_W-1:0] r;
    r = '0;
    for (int i = 0; i < OUT_W; i++) begin
      r[OUT_W-1-i] = c[SYM_BITS-1-(i % SYM_BITS)];
    end
    return r;
  endfunction

  assign wr_en   = sel & ~we;
  assign rd_en   = sel & we;
  assign wr_ctrl = wr_en && (addr == A_CTRL);
  assign wr_data = wr_en && (addr == A_DATA);
  assign wr_div  = wr_en && (addr == A_DIV);
  assign wr_stat = wr_en && (addr == A_STAT);

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign busy  = (state == ST_SHIFT);

  // TXEN as it will stand after this edge; a clearing write aborts the
  // shifter on the same edge that it lands, and also blocks a pop there.
  assign txen_nxt = wr_ctrl ? Data_in[0] : txen;

  assign sym_end    = busy && (div_cnt == '0);
  assign last_final = sym_end && (sym_idx == SW'(NSYM-1));
  assign abort      = busy && !txen_nxt;

  // Pop and FULL both look at the pre-edge count, so a push into an empty
  // FIFO is never popped on the same edge and a pop never makes room for
  // a simultaneous push.
  assign pop     = txen && txen_nxt && !empty && ((state == ST_IDLE) || last_final);
  assign push    = wr_data && !full;
  assign set_int = last_final && !pop && !abort;

  assign head_byte = mem[rd_ptr];
  assign shreg_sh  = shreg << SYM_BITS;

  assign BSG_INT = intflag & intmsk;

  always_comb begin
    rdata = 8'h00;
    case (addr)
      A_CTRL:  rdata = {3'b000, gray_en, busy, intflag, intmsk, txen};
      A_DIV:   rdata = 8'(div_q);
      A_LEVEL: rdata = 8'(count);
      A_STAT:  rdata = {5'b00000, ovf, full, empty};
      default: rdata = 8'h00;
    endcase
  end

  // FIFO storage needs no reset: only entries below LEVEL are ever read.
  always_ff @(posedge SYS_CLK) begin
    if (push) mem[wr_ptr] <= Data_in;
  end

  always_ff @(posedge SYS_CLK) begin
    if (!rst_n) begin
      txen     <= 1'b0;
      intmsk   <= 1'b0;
      intflag  <= 1'b0;
      gray_en  <= 1'b0;
      ovf      <= 1'b0;
      div_q    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      state    <= ST_IDLE;
      shreg    <= 8'h00;
      sym_idx  <= '0;
      div_cnt  <= '0;
      OUT      <= '0;
      Data_out <= 8'h00;
    end else begin
      if (wr_ctrl) begin
        txen    <= Data_in[0];
        intmsk  <= Data_in[1];
        gray_en <= Data_in[4];
      end
      if (wr_div) div_q <= DIV_W'(Data_in);

      // Set has priority over the write-one-to-clear.
      if (set_int)                     intflag <= 1'b1;
      else if (wr_ctrl && Data_in[2])  intflag <= 1'b0;

      if (wr_data && full)             ovf <= 1'b1;
      else if (wr_stat && Data_in[2])  ovf <= 1'b0;

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);

      if (rd_en) Data_out <= rdata;

      // The divider is reloaded from DIV only at symbol boundaries, so a
      // DIV write never stretches or shortens the symbol in flight.
      case (state)
        ST_IDLE: begin
          if (pop) begin
            state   <= ST_SHIFT;
            shreg   <= head_byte;
            sym_idx <= '0;
            div_cnt <= div_q;
            OUT     <= level(code_sym(head_byte[7 -: SYM_BITS], gray_en));
          end
        end
        ST_SHIFT: begin
          if (abort) begin
            state   <= ST_IDLE;
            shreg   <= 8'h00;
            sym_idx <= '0;
            div_cnt <= '0;
            OUT     <= '0;
          end else if (!sym_end) begin
            div_cnt <= div_cnt - 1'b1;
          end else if (!last_final) begin
            shreg   <= shreg_sh;
            sym_idx <= sym_idx + 1'b1;
            div_cnt <= div_q;
            OUT     <= level(code_sym(shreg_sh[7 -: SYM_BITS], gray_en));
          end else if (pop) begin
            // Next byte follows with no idle gap.
            shreg   <= head_byte;
            sym_idx <= '0;
            div_cnt <= div_q;
            OUT     <= level(code_sym(head_byte[7 -: SYM_BITS], gray_en));
          end else begin
            state   <= ST_IDLE;
            shreg   <= 8'h00;
            sym_idx <= '0;
            div_cnt <= '0;
            OUT     <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
